sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYC, default 2, strobe width in clocks (legal 1..15).
REQ-002 SHALL have parameter STARVE_LIM, default 4, max consecutive P0 grants while P1/P2 pend (legal 1..15).
REQ-003 iCLK  in  1  single clock; all logic on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 P0_REQ, P0_WE  in  1 each  port 0 (CPU) request; 1=write, 0=read.
REQ-006 P0_ADDR  in  17, P0_DI  in  16, P0_BE  in  2  port 0 address, write data, byte enables [1]=upper.
REQ-007 P0_ACK  out  1, P0_DO  out  16  port 0 completion pulse, read data.
REQ-008 P1_REQ, P2_REQ  in  1; P1_ADDR, P2_ADDR  in  17  read-only video/sprite ports.
REQ-009 P1_ACK, P2_ACK  out  1; P1_DO, P2_DO  out  16  completion pulse, read data.
REQ-010 SRAM_ADDR  out  17; SRAM_DQ_O  out  16; SRAM_DQ_I  in  16; SRAM_DQ_OE  out  1  (1=drive DQ).
REQ-011 SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.
REQ-012 BUSY  out  1 (state != IDLE); GRANT  out  2  owner: 00 none, 01 P0, 10 P1, 11 P2.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, STROBE, DONE.
REQ-014 IDLE: any REQ high at edge -> SETUP with winner; else stay.
REQ-015 Grant edge SHALL latch winner's address, P0_WE, P0_DI, P0_BE; later requester changes ignored for that access.
REQ-016 SETUP (1 cycle): SRAM_ADDR valid; read -> UB_N=LB_N=0, OE_N=1; write -> UB_N=~BE[1], LB_N=~BE[0], DQ_OE=1, DQ_O=data; WE_N=1.
REQ-017 STROBE (ACCESS_CYC cycles): read -> OE_N=0; write -> WE_N=0, DQ held; address/byte lanes stable.
REQ-018 Read data SHALL be captured from SRAM_DQ_I on last STROBE edge into owner's Px_DO.
REQ-019 DONE (1 cycle): OE_N=WE_N=1, DQ_OE=0, UB_N=LB_N=1, owner's Px_ACK=1 for exactly this cycle.
REQ-020 DONE: pending request -> SETUP (back-to-back, re-arbitrated); else IDLE.
REQ-021 Latency: REQ sampled at edge 0 in IDLE -> ACK high in cycle ACCESS_CYC+2; throughput one access per ACCESS_CYC+2 cycles.
REQ-022 Priority: P0 over P1/P2; P1 vs P2 round-robin, pointer toggles on each P1/P2 grant; after reset P1 wins first tie.
REQ-023 Starvation counter SHALL increment on P0 grant while P1 or P2 pends; at STARVE_LIM with P1/P2 pending, grant RR port and clear.
REQ-024 Counter SHALL clear on any P1/P2 grant or when no P1/P2 pending.
REQ-025 Px_DO SHALL hold until next read completion for that port; writes leave P0_DO unchanged.
REQ-026 P0 write with BE=00: full cycle run, both lanes masked, ACK issued.
REQ-027 REQ dropped before grant: no access; dropped after grant: access completes, ACK still pulses.
REQ-028 Requester SHALL hold REQ until ACK; REQ high in ACK cycle counts as new request.
REQ-029 Outside SETUP/STROBE: DQ_OE=0, OE_N=WE_N=UB_N=LB_N=1, SRAM_ADDR holds last value.

Reset
REQ-030 RST_N low SHALL immediately force: state IDLE, SRAM_ADDR=0, DQ_O=0, DQ_OE=0, all strobes 1, all ACK=0, all DO=0, BUSY=0, GRANT=00, counter 0, RR pointer to P1.
REQ-031 Reset mid-access SHALL abort without ACK; requester re-requests after release.
REQ-032 First grant SHALL occur no earlier than first rising edge after RST_N high.

Verification
REQ-033 P1 read 0x00010, SRAM_DQ_I=0xBEEF -> SETUP cycle 1, OE_N low cycles 2-3, P1_ACK cycle 4, P1_DO=0xBEEF.
REQ-034 P0 write 0x1F000, 0x1234, BE=10 -> UB_N=0, LB_N=1, WE_N low 2 cycles, DQ_OE=1 SETUP through STROBE, P0_ACK once.
REQ-035 P1 and P2 held continuously -> grants alternate P1,P2,P1,P2; back-to-back every 4 cycles, BUSY stays 1.
REQ-036 P0, P1 held continuously, STARVE_LIM=4 -> grant sequence P0x4, P1, P0x4, P1.
REQ-037 RST_N low during STROBE of write -> WE_N=1, DQ_OE=0 same cycle, no P0_ACK, all outputs at reset values.
REQ-038 P2 REQ pulsed 1 cycle while P0 busy -> no P2 access, no P2_ACK.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - three requester ports, async SRAM pins and status for sram_arbiter
interface sram_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [16:0] p0_addr;
  logic [15:0] p0_di;
  logic [1:0]  p0_be;
  logic        p0_ack;
  logic [15:0] p0_do;

  logic        p1_req;
  logic [16:0] p1_addr;
  logic        p1_ack;
  logic [15:0] p1_do;

  logic        p2_req;
  logic [16:0] p2_addr;
  logic        p2_ack;
  logic [15:0] p2_do;

  logic [16:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  logic        busy;
  logic [1:0]  grant;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_di, p0_be, p1_req, p1_addr, p2_req, p2_addr, sram_dq_i,
    output p0_ack, p0_do, p1_ack, p1_do, p2_ack, p2_do,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    output busy, grant
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_di, p0_be, p1_req, p1_addr, p2_req, p2_addr, sram_dq_i,
    input  p0_ack, p0_do, p1_ack, p1_do, p2_ack, p2_do,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    input  busy, grant
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-port arbiter for a 128Kx16 async SRAM
// P0 has fixed priority with a starvation limit; P1/P2 alternate round-robin.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic          clk,
  input logic          rst_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_P0   = 2'b01;
  localparam logic [1:0] OWN_P1   = 2'b10;
  localparam logic [1:0] OWN_P2   = 2'b11;

  localparam logic [3:0] STROBE_LAST = 4'(ACCESS_CYC - 1);
  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIM);

  state_t      state_q, state_next;
  logic [3:0]  strobe_cnt_q;
  logic [1:0]  owner_q;
  logic [16:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic [1:0]  be_q;
  logic [3:0]  starve_q;
  logic        rr_q;
  logic [15:0] p0_do_q, p1_do_q, p2_do_q;

  logic        p12_pend;
  logic        starve_hit;
  logic        strobe_last;
  logic [1:0]  rr_pick;
  logic [1:0]  winner;
  logic        grant_now;

  logic        oe_n, we_n, ub_n, lb_n, dq_oe;
  logic        p0_ack, p1_ack, p2_ack;

  assign strobe_last = (strobe_cnt_q == STROBE_LAST);

  // Arbitration is evaluated every cycle but only acted on in IDLE or DONE.
  always_comb begin
    p12_pend   = bus.p1_req | bus.p2_req;
    starve_hit = p12_pend && (starve_q >= STARVE_MAX);
    if (bus.p1_req && bus.p2_req) begin
      rr_pick = rr_q ? OWN_P2 : OWN_P1;
    end else if (bus.p1_req) begin
      rr_pick = OWN_P1;
    end else begin
      rr_pick = OWN_P2;
    end
    winner = OWN_NONE;
    if (bus.p0_req && !starve_hit) begin
      winner = OWN_P0;
    end else if (p12_pend) begin
      winner = rr_pick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    grant_now  = 1'b0;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    ub_n       = 1'b1;
    lb_n       = 1'b1;
    dq_oe      = 1'b0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;
    p2_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner != OWN_NONE) begin
          grant_now  = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = STROBE;
        if (we_q) begin
          ub_n  = ~be_q[1];
          lb_n  = ~be_q[0];
          dq_oe = 1'b1;
        end else begin
          ub_n = 1'b0;
          lb_n = 1'b0;
        end
      end
      STROBE: begin
        if (strobe_last) begin
          state_next = DONE;
        end
        if (we_q) begin
          ub_n  = ~be_q[1];
          lb_n  = ~be_q[0];
          dq_oe = 1'b1;
          we_n  = 1'b0;
        end else begin
          ub_n = 1'b0;
          lb_n = 1'b0;
          oe_n = 1'b0;
        end
      end
      DONE: begin
        p0_ack = (owner_q == OWN_P0);
        p1_ack = (owner_q == OWN_P1);
        p2_ack = (owner_q == OWN_P2);
        if (winner != OWN_NONE) begin
          grant_now  = 1'b1;
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_cnt_q <= 4'd0;
      owner_q      <= OWN_NONE;
      addr_q       <= 17'd0;
      wdata_q      <= 16'd0;
      we_q         <= 1'b0;
      be_q         <= 2'b00;
      starve_q     <= 4'd0;
      rr_q         <= 1'b0;
      p0_do_q      <= 16'd0;
      p1_do_q      <= 16'd0;
      p2_do_q      <= 16'd0;
    end else begin
      if ((state_q == STROBE) && !strobe_last) begin
        strobe_cnt_q <= strobe_cnt_q + 4'd1;
      end else begin
        strobe_cnt_q <= 4'd0;
      end

      // Request fields are latched once; the requester may change them afterwards.
      if (grant_now) begin
        owner_q <= winner;
        case (winner)
          OWN_P0: begin
            addr_q  <= bus.p0_addr;
            we_q    <= bus.p0_we;
            wdata_q <= bus.p0_di;
            be_q    <= bus.p0_be;
          end
          OWN_P1: begin
            addr_q <= bus.p1_addr;
            we_q   <= 1'b0;
          end
          OWN_P2: begin
            addr_q <= bus.p2_addr;
            we_q   <= 1'b0;
          end
          default: ;
        endcase
      end else if (state_q == DONE) begin
        owner_q <= OWN_NONE;
      end

      if (grant_now && winner[1]) begin
        rr_q <= ~rr_q;
      end

      if (!p12_pend || (grant_now && winner[1])) begin
        starve_q <= 4'd0;
      end else if (grant_now && (winner == OWN_P0) && (starve_q != 4'hF)) begin
        starve_q <= starve_q + 4'd1;
      end

      if ((state_q == STROBE) && strobe_last && !we_q) begin
        case (owner_q)
          OWN_P0:  p0_do_q <= bus.sram_dq_i;
          OWN_P1:  p1_do_q <= bus.sram_dq_i;
          OWN_P2:  p2_do_q <= bus.sram_dq_i;
          default: ;
        endcase
      end
    end
  end

  assign bus.sram_addr  = addr_q;
  assign bus.sram_dq_o  = wdata_q;
  assign bus.sram_dq_oe = dq_oe;
  assign bus.sram_oe_n  = oe_n;
  assign bus.sram_we_n  = we_n;
  assign bus.sram_ub_n  = ub_n;
  assign bus.sram_lb_n  = lb_n;
  assign bus.p0_ack     = p0_ack;
  assign bus.p1_ack     = p1_ack;
  assign bus.p2_ack     = p2_ack;
  assign bus.p0_do      = p0_do_q;
  assign bus.p1_do      = p1_do_q;
  assign bus.p2_do      = p2_do_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant      = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector table plus corner sequences for sram_arbiter
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(.ACCESS_CYC(2), .STARVE_LIM(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // {oe_n, we_n, ub_n, lb_n, dq_oe}
  localparam logic [4:0] S_IDL   = 5'b11110;
  localparam logic [4:0] S_RD_SU = 5'b11000;
  localparam logic [4:0] S_RD_ST = 5'b01000;
  localparam logic [4:0] S_WU_SU = 5'b11011;
  localparam logic [4:0] S_WU_ST = 5'b10011;
  localparam logic [4:0] S_W0_SU = 5'b11111;
  localparam logic [4:0] S_W0_ST = 5'b10111;

  typedef struct packed {
    logic        p0_req;
    logic        p0_we;
    logic [16:0] p0_addr;
    logic [15:0] p0_di;
    logic [1:0]  p0_be;
    logic        p1_req;
    logic [16:0] p1_addr;
    logic        p2_req;
    logic [16:0] p2_addr;
    logic [15:0] dq_i;
    logic [1:0]  e_grant;
    logic        e_busy;
    logic [4:0]  e_strb;
    logic [2:0]  e_ack;
    logic [16:0] e_addr;
    logic [15:0] e_dq_o;
    logic [15:0] e_p0_do;
    logic [15:0] e_p1_do;
    logic [15:0] e_p2_do;
  } vec_t;

  logic [91:0] obs;
  assign obs = {bus.grant, bus.busy, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n,
                bus.sram_dq_oe, bus.p0_ack, bus.p1_ack, bus.p2_ack, bus.sram_addr, bus.sram_dq_o,
                bus.p0_do, bus.p1_do, bus.p2_do};

  function automatic vec_t v(
    input logic p0r, input logic p0w, input logic [16:0] p0a, input logic [15:0] p0d,
    input logic [1:0] p0b, input logic p1r, input logic [16:0] p1a, input logic p2r,
    input logic [16:0] p2a, input logic [15:0] dqi, input logic [1:0] eg, input logic eb,
    input logic [4:0] es, input logic [2:0] ea, input logic [16:0] ead, input logic [15:0] edq,
    input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    vec_t r;
    r = {p0r, p0w, p0a, p0d, p0b, p1r, p1a, p2r, p2a, dqi, eg, eb, es, ea, ead, edq, e0, e1, e2};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 17'h0; bus.p0_di = 16'h0; bus.p0_be = 2'b00;
    bus.p1_req = 1'b0; bus.p1_addr = 17'h0; bus.p2_req = 1'b0; bus.p2_addr = 17'h0;
    bus.sram_dq_i = 16'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input vec_t x);
    bus.p0_req = x.p0_req; bus.p0_we = x.p0_we; bus.p0_addr = x.p0_addr;
    bus.p0_di = x.p0_di; bus.p0_be = x.p0_be;
    bus.p1_req = x.p1_req; bus.p1_addr = x.p1_addr;
    bus.p2_req = x.p2_req; bus.p2_addr = x.p2_addr;
    bus.sram_dq_i = x.dq_i;
  endtask

  vec_t vt[21];
  int   got[10];
  int   exp_seq[10];
  int   n_ack;
  int   a1, a2;

  initial begin
    clear_inputs();
    #1;
    chk("reset_state", 128'(obs), 128'({2'b00, 1'b0, S_IDL, 3'b000, 17'h0, 16'h0, 16'h0, 16'h0, 16'h0}));
    @(negedge clk);
    rst_n = 1'b1;

    // P1 read, P0 upper-byte write, P0 masked write, P0 read with a one-cycle P2 pulse.
    vt[0]  = v(1'b0,1'b0,17'h0,16'h0,2'b00, 1'b1,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd2,1'b1,S_RD_SU,3'b000,17'h10,16'h0,16'h0,16'h0,16'h0);
    vt[1]  = v(1'b0,1'b0,17'h0,16'h0,2'b00, 1'b1,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd2,1'b1,S_RD_ST,3'b000,17'h10,16'h0,16'h0,16'h0,16'h0);
    vt[2]  = v(1'b0,1'b0,17'h0,16'h0,2'b00, 1'b1,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd2,1'b1,S_RD_ST,3'b000,17'h10,16'h0,16'h0,16'h0,16'h0);
    vt[3]  = v(1'b0,1'b0,17'h0,16'h0,2'b00, 1'b1,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd2,1'b1,S_IDL,3'b010,17'h10,16'h0,16'h0,16'hBEEF,16'h0);
    vt[4]  = v(1'b0,1'b0,17'h0,16'h0,2'b00, 1'b0,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd0,1'b0,S_IDL,3'b000,17'h10,16'h0,16'h0,16'hBEEF,16'h0);
    vt[5]  = v(1'b1,1'b1,17'h1F000,16'h1234,2'b10, 1'b0,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd1,1'b1,S_WU_SU,3'b000,17'h1F000,16'h1234,16'h0,16'hBEEF,16'h0);
    vt[6]  = v(1'b1,1'b1,17'h00000,16'hFFFF,2'b01, 1'b0,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd1,1'b1,S_WU_ST,3'b000,17'h1F000,16'h1234,16'h0,16'hBEEF,16'h0);
    vt[7]  = v(1'b1,1'b1,17'h00000,16'hFFFF,2'b01, 1'b0,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd1,1'b1,S_WU_ST,3'b000,17'h1F000,16'h1234,16'h0,16'hBEEF,16'h0);
    vt[8]  = v(1'b1,1'b1,17'h00000,16'hFFFF,2'b01, 1'b0,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd1,1'b1,S_IDL,3'b100,17'h1F000,16'h1234,16'h0,16'hBEEF,16'h0);
    vt[9]  = v(1'b0,1'b1,17'h00000,16'hFFFF,2'b01, 1'b0,17'h10, 1'b0,17'h0, 16'hBEEF, 2'd0,1'b0,S_IDL,3'b000,17'h1F000,16'h1234,16'h0,16'hBEEF,16'h0);
    vt[10] = v(1'b1,1'b1,17'h00005,16'hAAAA,2'b00, 1'b0,17'h10, 1'b0,17'h0, 16'h0, 2'd1,1'b1,S_W0_SU,3'b000,17'h5,16'hAAAA,16'h0,16'hBEEF,16'h0);
    vt[11] = v(1'b1,1'b1,17'h00005,16'hAAAA,2'b00, 1'b0,17'h10, 1'b0,17'h0, 16'h0, 2'd1,1'b1,S_W0_ST,3'b000,17'h5,16'hAAAA,16'h0,16'hBEEF,16'h0);
    vt[12] = v(1'b1,1'b1,17'h00005,16'hAAAA,2'b00, 1'b0,17'h10, 1'b0,17'h0, 16'h0, 2'd1,1'b1,S_W0_ST,3'b000,17'h5,16'hAAAA,16'h0,16'hBEEF,16'h0);
    vt[13] = v(1'b1,1'b1,17'h00005,16'hAAAA,2'b00, 1'b0,17'h10, 1'b0,17'h0, 16'h0, 2'd1,1'b1,S_IDL,3'b100,17'h5,16'hAAAA,16'h0,16'hBEEF,16'h0);
    vt[14] = v(1'b0,1'b1,17'h00005,16'hAAAA,2'b00, 1'b0,17'h10, 1'b0,17'h0, 16'h0, 2'd0,1'b0,S_IDL,3'b000,17'h5,16'hAAAA,16'h0,16'hBEEF,16'h0);
    vt[15] = v(1'b1,1'b0,17'h00022,16'hAAAA,2'b11, 1'b0,17'h10, 1'b0,17'h0, 16'h5A5A, 2'd1,1'b1,S_RD_SU,3'b000,17'h22,16'hAAAA,16'h0,16'hBEEF,16'h0);
    vt[16] = v(1'b1,1'b0,17'h00022,16'hAAAA,2'b11, 1'b0,17'h10, 1'b1,17'h33, 16'h5A5A, 2'd1,1'b1,S_RD_ST,3'b000,17'h22,16'hAAAA,16'h0,16'hBEEF,16'h0);
    vt[17] = v(1'b1,1'b0,17'h00022,16'hAAAA,2'b11, 1'b0,17'h10, 1'b0,17'h33, 16'h5A5A, 2'd1,1'b1,S_RD_ST,3'b000,17'h22,16'hAAAA,16'h0,16'hBEEF,16'h0);
    vt[18] = v(1'b1,1'b0,17'h00022,16'hAAAA,2'b11, 1'b0,17'h10, 1'b0,17'h33, 16'h5A5A, 2'd1,1'b1,S_IDL,3'b100,17'h22,16'hAAAA,16'h5A5A,16'hBEEF,16'h0);
    vt[19] = v(1'b0,1'b0,17'h00022,16'hAAAA,2'b11, 1'b0,17'h10, 1'b0,17'h33, 16'h5A5A, 2'd0,1'b0,S_IDL,3'b000,17'h22,16'hAAAA,16'h5A5A,16'hBEEF,16'h0);
    vt[20] = v(1'b0,1'b0,17'h00022,16'hAAAA,2'b11, 1'b0,17'h10, 1'b0,17'h33, 16'h5A5A, 2'd0,1'b0,S_IDL,3'b000,17'h22,16'hAAAA,16'h5A5A,16'hBEEF,16'h0);

    for (int i = 0; i < 21; i++) begin
      drive(vt[i]);
      tick();
      chk($sformatf("vec%0d", i), 128'(obs),
          128'({vt[i].e_grant, vt[i].e_busy, vt[i].e_strb, vt[i].e_ack, vt[i].e_addr,
                vt[i].e_dq_o, vt[i].e_p0_do, vt[i].e_p1_do, vt[i].e_p2_do}));
    end

    // P1 and P2 held together: alternating 4-cycle accesses starting with P1.
    do_reset();
    bus.p1_req = 1'b1; bus.p1_addr = 17'h100;
    bus.p2_req = 1'b1; bus.p2_addr = 17'h200;
    bus.sram_dq_i = 16'hC0DE;
    a1 = 0; a2 = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("rr_grant_c%0d", k), 128'({bus.busy, bus.grant}),
          128'({1'b1, (((k - 1) / 4) % 2 == 1) ? 2'd3 : 2'd2}));
      if (bus.p1_ack) a1 = a1 + 1;
      if (bus.p2_ack) a2 = a2 + 1;
    end
    chk("rr_ack_counts", 128'({a1[7:0], a2[7:0]}), 128'({8'd2, 8'd2}));
    chk("rr_p2_do", 128'(bus.p2_do), 128'(16'hC0DE));
    clear_inputs();

    // P0 and P1 held: four P0 accesses then one P1, repeated.
    do_reset();
    bus.p0_req = 1'b1; bus.p0_addr = 17'h1;
    bus.p1_req = 1'b1; bus.p1_addr = 17'h2;
    exp_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    n_ack = 0;
    for (int c = 0; c < 60 && n_ack < 10; c++) begin
      tick();
      if (bus.p0_ack && n_ack < 10) begin got[n_ack] = 1; n_ack = n_ack + 1; end
      if (bus.p1_ack && n_ack < 10) begin got[n_ack] = 2; n_ack = n_ack + 1; end
    end
    chk("starve_ack_count", 128'(n_ack), 128'(10));
    for (int j = 0; j < 10; j++) begin
      if (j < n_ack) chk($sformatf("starve_seq%0d", j), 128'(got[j]), 128'(exp_seq[j]));
    end
    clear_inputs();

    // Reset asserted during the strobe of a write aborts it with no acknowledge.
    do_reset();
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 17'h0ABC; bus.p0_di = 16'h5555; bus.p0_be = 2'b11;
    tick();
    tick();
    chk("abort_pre_we_n", 128'({bus.sram_we_n, bus.sram_dq_oe}), 128'({1'b0, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_reset_values", 128'(obs), 128'({2'b00, 1'b0, S_IDL, 3'b000, 17'h0, 16'h0, 16'h0, 16'h0, 16'h0}));
    bus.p0_req = 1'b0;
    tick();
    chk("abort_held_in_reset", 128'(obs), 128'({2'b00, 1'b0, S_IDL, 3'b000, 17'h0, 16'h0, 16'h0, 16'h0, 16'h0}));
    #2;
    bus.p0_req = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("no_grant_before_edge", 128'({bus.busy, bus.grant}), 128'({1'b0, 2'd0}));
    tick();
    chk("grant_after_release", 128'({bus.busy, bus.grant, bus.sram_addr}), 128'({1'b1, 2'd1, 17'h0ABC}));
    n_ack = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.p0_ack) begin
        n_ack = n_ack + 1;
        bus.p0_req = 1'b0;
      end
    end
    chk("rerequest_ack_once", 128'(n_ack), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
